// File: rtl/broadcast_queue_pkg.sv
// broadcast_queue_pkg: shared FU/CDB widths, entry layout and FU index map
package broadcast_queue_pkg;
    localparam int BQ_NUM_FU      = 4;
    localparam int BQ_DATA_WIDTH  = 32;
    localparam int BQ_TAG_WIDTH   = 7;
    localparam int ENTRY_DATA_LSB = 0;
    localparam int ENTRY_TAG_LSB  = ENTRY_DATA_LSB + BQ_DATA_WIDTH;
    typedef enum logic [1:0] {FU_ADD, FU_MUL, FU_LSU, FU_BRU} fu_id_e;
    typedef struct packed {
        logic [BQ_TAG_WIDTH-1:0]  tag;
        logic [BQ_DATA_WIDTH-1:0] data;
    } cdb_entry_t;
endpackage

// File: rtl/bq_grant.sv
// bq_grant: prefix-count of done pulses against free slots -> grants, write offsets, write count
module bq_grant
    import broadcast_queue_pkg::*;
#(
    parameter int NUM_FU = BQ_NUM_FU,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic                 rst,
    input  logic [NUM_FU-1:0]    fu_done,
    input  logic [CW-1:0]        count,
    output logic [NUM_FU-1:0]    fu_queued,
    output logic [NUM_FU*AW-1:0] offset,
    output logic [CW-1:0]        n_wr
);
    logic [CW-1:0] free;
    logic [CW-1:0] rank;
    // Walk FUs lowest index first; each requester's rank is its slot offset and must fit in free space
    always_comb begin
        free      = CW'(DEPTH) - count;
        rank      = '0;
        n_wr      = '0;
        fu_queued = '0;
        offset    = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            offset[i*AW +: AW] = rank[AW-1:0];
            fu_queued[i]       = fu_done[i] & (rank < free) & ~rst;
            n_wr               = n_wr + CW'(fu_queued[i]);
            rank               = rank + CW'(fu_done[i]);
        end
    end
endmodule

// File: rtl/broadcast_queue.sv
// broadcast_queue: multi-write FU result capture FIFO draining one entry per cycle onto the CDB
module broadcast_queue
    import broadcast_queue_pkg::*;
#(
    parameter int NUM_FU     = BQ_NUM_FU,
    parameter int DATA_WIDTH = BQ_DATA_WIDTH,
    parameter int TAG_WIDTH  = BQ_TAG_WIDTH,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_FU-1:0]            fu_done,
    input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
    output logic [NUM_FU-1:0]            fu_queued,
    output logic                         cdb_valid,
    output logic [TAG_WIDTH-1:0]         cdb_tag,
    output logic [DATA_WIDTH-1:0]        cdb_data,
    input  logic                         cdb_ready,
    output logic [CW-1:0]                count
);
    localparam int EW      = TAG_WIDTH + DATA_WIDTH;
    localparam int TAG_LSB = ENTRY_DATA_LSB + DATA_WIDTH;

    logic [EW-1:0]        mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [NUM_FU*AW-1:0] offset;
    logic [CW-1:0]        n_wr;
    logic                 pop;

    bq_grant #(.NUM_FU(NUM_FU), .DEPTH(DEPTH)) u_grant (
        .rst       (rst),
        .fu_done   (fu_done),
        .count     (count),
        .fu_queued (fu_queued),
        .offset    (offset),
        .n_wr      (n_wr)
    );

    assign cdb_valid = count != '0;
    assign pop       = cdb_valid & cdb_ready;
    assign cdb_tag   = mem[rd_ptr][TAG_LSB +: TAG_WIDTH];
    assign cdb_data  = mem[rd_ptr][ENTRY_DATA_LSB +: DATA_WIDTH];

    // Granted FUs land in consecutive slots from wr_ptr; AW-bit address sum wraps modulo DEPTH
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++)
            if (fu_queued[i])
                mem[wr_ptr + offset[i*AW +: AW]] <= {fu_tag[i*TAG_WIDTH +: TAG_WIDTH], fu_result[i*DATA_WIDTH +: DATA_WIDTH]};
    end

    // Pointers and occupancy advance by the write count and the pop in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_wr[AW-1:0];
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + n_wr - CW'(pop);
        end
    end
endmodule

// File: tb/tb_broadcast_queue.sv
// tb_broadcast_queue: directed scenarios plus randomized traffic against a queue-based reference model
module tb_broadcast_queue;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   fu_done = '0;
    logic [27:0]  fu_tag = '0;
    logic [127:0] fu_result = '0;
    logic [3:0]   fu_queued;
    logic         cdb_valid;
    logic [6:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic         cdb_ready = 1'b0;
    logic [3:0]   count;

    int checks = 0;
    int failures = 0;
    logic [38:0] q[$];

    broadcast_queue dut (
        .clk       (clk),
        .rst       (rst),
        .fu_done   (fu_done),
        .fu_tag    (fu_tag),
        .fu_result (fu_result),
        .fu_queued (fu_queued),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_ready (cdb_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_grant();
        int k;
        int free;
        logic [3:0] g;
        k = 0;
        free = 8 - q.size();
        g = '0;
        if (rst) return '0;
        for (int i = 0; i < 4; i++)
            if (fu_done[i]) begin
                if (k < free) g[i] = 1'b1;
                k++;
            end
        return g;
    endfunction

    task automatic drive(input logic [3:0] d, input logic rdy, input logic rs);
        fu_done = d;
        cdb_ready = rdy;
        rst = rs;
        for (int i = 0; i < 4; i++) begin
            fu_tag[i*7 +: 7] = 7'($urandom);
            fu_result[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic commit();
        logic [3:0] g;
        @(posedge clk);
        g = exp_grant();
        if (rst) q.delete();
        else begin
            if (q.size() != 0 && cdb_ready) void'(q.pop_front());
            for (int i = 0; i < 4; i++)
                if (g[i]) q.push_back({fu_tag[i*7 +: 7], fu_result[i*32 +: 32]});
        end
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(4'($urandom), 1'b1, 1'b1);
            @(negedge clk);
            checks++;
            if (fu_queued !== 4'b0000) begin failures++; $display("FAIL reset_queued got=%b want=0000", fu_queued); end
            commit();
        end
        for (int c = 0; c < 4; c++) begin
            drive(4'b0000, c != 0, 1'b0);
            @(negedge clk);
            checks++;
            if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
            checks++;
            if (cdb_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", cdb_valid); end
            checks++;
            if (fu_queued !== 4'b0000) begin failures++; $display("FAIL reset_idle_queued got=%b want=0000", fu_queued); end
            commit();
        end
    endtask

    task automatic test_single();
        drive(4'b0001, 1'b1, 1'b0);
        fu_tag[6:0] = 7'h05;
        fu_result[31:0] = 32'h0000_0003;
        @(negedge clk);
        checks++;
        if (fu_queued !== 4'b0001) begin failures++; $display("FAIL single_queued got=%b want=0001", fu_queued); end
        checks++;
        if (cdb_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%b want=0", cdb_valid); end
        commit();
        drive(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (cdb_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b want=1", cdb_valid); end
        checks++;
        if ({cdb_tag, cdb_data} !== {7'h05, 32'h3}) begin failures++; $display("FAIL single_head got=%h/%h want=05/00000003", cdb_tag, cdb_data); end
        commit();
        drive(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (count !== 4'd0) begin failures++; $display("FAIL single_drain got=%0d want=0", count); end
        commit();
    endtask

    task automatic test_multi_order();
        logic [6:0] want [3];
        want = '{7'h10, 7'h11, 7'h13};
        drive(4'b1011, 1'b0, 1'b0);
        fu_tag[6:0] = 7'h10;
        fu_tag[13:7] = 7'h11;
        fu_tag[27:21] = 7'h13;
        @(negedge clk);
        checks++;
        if (fu_queued !== 4'b1011) begin failures++; $display("FAIL multi_queued got=%b want=1011", fu_queued); end
        commit();
        drive(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (count !== 4'd3) begin failures++; $display("FAIL multi_count got=%0d want=3", count); end
        commit();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0000, 1'b1, 1'b0);
            @(negedge clk);
            checks++;
            if (cdb_valid !== 1'b1 || cdb_tag !== want[k]) begin
                failures++;
                $display("FAIL multi_order[%0d] got=%b/%h want=1/%h", k, cdb_valid, cdb_tag, want[k]);
            end
            commit();
        end
    endtask

    task automatic test_full_partial();
        drive(4'b1111, 1'b0, 1'b0);
        commit();
        drive(4'b0011, 1'b0, 1'b0);
        commit();
        drive(4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (count !== 4'd6) begin failures++; $display("FAIL fill_count got=%0d want=6", count); end
        checks++;
        if (fu_queued !== 4'b0011) begin failures++; $display("FAIL partial_queued got=%b want=0011", fu_queued); end
        commit();
        drive(4'b0100, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d want=8", count); end
        checks++;
        if (fu_queued !== 4'b0000) begin failures++; $display("FAIL full_queued got=%b want=0000", fu_queued); end
        commit();
    endtask

    task automatic test_random(input int n);
        logic [3:0] g;
        for (int c = 0; c < n; c++) begin
            drive(4'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0);
            @(negedge clk);
            g = exp_grant();
            checks++;
            if (fu_queued !== g) begin failures++; $display("FAIL rand_queued cyc=%0d got=%b want=%b", c, fu_queued, g); end
            checks++;
            if (count !== 4'(q.size())) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d want=%0d", c, count, q.size()); end
            checks++;
            if (cdb_valid !== (q.size() != 0)) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, cdb_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++;
                if ({cdb_tag, cdb_data} !== q[0]) begin
                    failures++;
                    $display("FAIL rand_head cyc=%0d got=%h/%h want=%h/%h", c, cdb_tag, cdb_data, q[0][38:32], q[0][31:0]);
                end
            end
            commit();
        end
    endtask

    task automatic test_pop_full_wrap();
        drive(4'b0001, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (fu_queued !== 4'b0000) begin failures++; $display("FAIL popfull_queued got=%b want=0000", fu_queued); end
        checks++;
        if (cdb_valid !== 1'b1) begin failures++; $display("FAIL popfull_valid got=%b want=1", cdb_valid); end
        commit();
        drive(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (count !== 4'd7) begin failures++; $display("FAIL popfull_count got=%0d want=7", count); end
        commit();
        test_random(20);
    endtask

    task automatic test_reset_mid();
        drive(4'b0000, 1'b0, 1'b1);
        commit();
        drive(4'b1111, 1'b0, 1'b0);
        commit();
        drive(4'b0001, 1'b0, 1'b0);
        commit();
        drive(4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (count !== 4'd5) begin failures++; $display("FAIL mid_pre_count got=%0d want=5", count); end
        commit();
        drive(4'b0010, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (fu_queued !== 4'b0000) begin failures++; $display("FAIL mid_queued got=%b want=0000", fu_queued); end
        commit();
        drive(4'b0000, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (count !== 4'd0) begin failures++; $display("FAIL mid_count got=%0d want=0", count); end
        checks++;
        if (cdb_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b want=0", cdb_valid); end
        commit();
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_order();
        test_full_partial();
        test_pop_full_wrap();
        test_reset_mid();
        test_random(400);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
